// File: rtl/sensor_conditioner_pkg.sv
// Shared constants and fault-FSM encoding for the sensor conditioner.
package sensor_conditioner_pkg;

    localparam int unsigned DEB_LEN_DEF   = 50000;
    localparam int unsigned FAULT_LEN_DEF = 500000;
    localparam int unsigned CNT_W         = 16;
    localparam int unsigned TMR_W         = 20;
    localparam int unsigned NUM_CH        = 4;

    // Channel slots inside the debounced level vector
    localparam int unsigned CH_US   = 0;
    localparam int unsigned CH_BS   = 1;
    localparam int unsigned CH_VS   = 2;
    localparam int unsigned CH_ADUB = 3;

    typedef enum logic [1:0] {
        ST_OK      = 2'd0,
        ST_SUSPECT = 2'd1,
        ST_FAULT   = 2'd2,
        ST_RECOVER = 2'd3
    } fault_state_e;

endpackage

// File: rtl/debounce_ch.sv
// One input channel: 2-flop synchronizer, disagreement counter and stable level flop.
module debounce_ch
    import sensor_conditioner_pkg::*;
#(
    parameter int unsigned DEB_LEN = DEB_LEN_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic stable,
    output logic stable_nxt_c
);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counter only runs while the synced level disagrees; it never exceeds DEB_LEN-1
    always_comb begin
        sync1_d  = raw;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_W'(DEB_LEN - 1)) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable       = stable_q;
    assign stable_nxt_c = stable_d;

endmodule

// File: rtl/sensor_conditioner.sv
// Debounces four irrigation sensors, flags inconsistent tank level sensors and pulses Chg on updates.
module sensor_conditioner
    import sensor_conditioner_pkg::*;
#(
    parameter int unsigned DEB_LEN   = DEB_LEN_DEF,
    parameter int unsigned FAULT_LEN = FAULT_LEN_DEF
) (
    input  logic Clk,
    input  logic Rst,
    input  logic Us_raw,
    input  logic Bs_raw,
    input  logic Vs_raw,
    input  logic Adub_raw,
    output logic Us,
    output logic Bs,
    output logic Vs,
    output logic Adub,
    output logic Chg,
    output logic Fault
);

    logic [NUM_CH-1:0] raw_vec;
    logic [NUM_CH-1:0] stab_vec;
    logic [NUM_CH-1:0] stab_nxt_vec;

    fault_state_e      state_q, state_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [4:0]        out_q, out_d;
    logic [NUM_CH:0]   prev_q, prev_d;
    logic              chg_q, chg_d;
    logic              fault_d;
    logic              incons_c;

    assign raw_vec = {Adub_raw, Vs_raw, Bs_raw, Us_raw};

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        debounce_ch #(
            .DEB_LEN(DEB_LEN)
        ) u_ch (
            .clk         (Clk),
            .rst_n       (Rst),
            .raw         (raw_vec[i]),
            .stable      (stab_vec[i]),
            .stable_nxt_c(stab_nxt_vec[i])
        );
    end

    // High mark wet while low mark dry cannot happen with healthy sensors
    assign incons_c = stab_vec[CH_VS] & ~stab_vec[CH_BS];

    always_comb begin
        state_d = state_q;
        timer_d = '0;
        case (state_q)
            ST_OK: begin
                if (incons_c) state_d = ST_SUSPECT;
            end
            ST_SUSPECT: begin
                if (!incons_c) begin
                    state_d = ST_OK;
                end else if (timer_q == TMR_W'(FAULT_LEN - 1)) begin
                    state_d = ST_FAULT;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_FAULT: begin
                if (!incons_c) state_d = ST_RECOVER;
            end
            ST_RECOVER: begin
                if (incons_c) begin
                    state_d = ST_FAULT;
                end else if (timer_q == TMR_W'(FAULT_LEN - 1)) begin
                    state_d = ST_OK;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: state_d = ST_OK;
        endcase

        fault_d = (state_d == ST_FAULT) || (state_d == ST_RECOVER);

        // Tank reads empty while faulted; internal levels keep tracking
        out_d = {stab_nxt_vec[CH_US],
                 stab_nxt_vec[CH_BS] & ~fault_d,
                 stab_nxt_vec[CH_VS] & ~fault_d,
                 stab_nxt_vec[CH_ADUB],
                 fault_d};

        prev_d = {stab_vec, out_q[0]};
        chg_d  = (prev_d != prev_q);
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q <= ST_OK;
            timer_q <= '0;
            out_q   <= '0;
            prev_q  <= '0;
            chg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            out_q   <= out_d;
            prev_q  <= prev_d;
            chg_q   <= chg_d;
        end
    end

    assign Us    = out_q[4];
    assign Bs    = out_q[3];
    assign Vs    = out_q[2];
    assign Adub  = out_q[1];
    assign Fault = out_q[0];
    assign Chg   = chg_q;

endmodule

// File: tb/tb_sensor_conditioner.sv
// Bench for sensor_conditioner with short debounce/fault windows and a streak-based reference model.
module tb_sensor_conditioner;

    localparam int unsigned DEB = 4;
    localparam int unsigned FL  = 8;

    logic Clk = 1'b0;
    logic Rst = 1'b0;
    logic Us_raw = 1'b0, Bs_raw = 1'b0, Vs_raw = 1'b0, Adub_raw = 1'b0;
    logic Us, Bs, Vs, Adub, Chg, Fault;

    int n_cmp = 0;
    int n_bad = 0;

    sensor_conditioner #(.DEB_LEN(DEB), .FAULT_LEN(FL)) dut (
        .Clk(Clk), .Rst(Rst),
        .Us_raw(Us_raw), .Bs_raw(Bs_raw), .Vs_raw(Vs_raw), .Adub_raw(Adub_raw),
        .Us(Us), .Bs(Bs), .Vs(Vs), .Adub(Adub), .Chg(Chg), .Fault(Fault)
    );

    always #5 Clk = ~Clk;

    // Reference: bit 0=Us 1=Bs 2=Vs 3=Adub. A level flips after DEB consecutive disagreeing
    // synced samples; the fault flag flips after FL+1 consecutive cycles disagreeing with it.
    bit [3:0]    m_s1, m_s2, m_stab, m_pstab;
    int unsigned m_dis [4];
    bit          m_mf, m_pmf, m_chg;
    int unsigned m_streak;

    function automatic void model_step();
        bit [3:0] raw;
        bit       cond;
        raw = {Adub_raw, Vs_raw, Bs_raw, Us_raw};
        if (!Rst) begin
            m_s1 = '0; m_s2 = '0; m_stab = '0; m_pstab = '0;
            for (int i = 0; i < 4; i++) m_dis[i] = 0;
            m_mf = 1'b0; m_pmf = 1'b0; m_chg = 1'b0; m_streak = 0;
            return;
        end
        cond    = m_stab[2] & ~m_stab[1];
        m_chg   = (m_stab != m_pstab) || (m_mf != m_pmf);
        m_pstab = m_stab;
        m_pmf   = m_mf;
        for (int i = 0; i < 4; i++) begin
            if (m_s2[i] != m_stab[i]) begin
                m_dis[i]++;
                if (m_dis[i] == DEB) begin
                    m_stab[i] = m_s2[i];
                    m_dis[i]  = 0;
                end
            end else begin
                m_dis[i] = 0;
            end
        end
        m_s2 = m_s1;
        m_s1 = raw;
        if (cond != m_mf) begin
            m_streak++;
            if (m_streak == FL + 1) begin
                m_mf     = ~m_mf;
                m_streak = 0;
            end
        end else begin
            m_streak = 0;
        end
    endfunction

    function automatic logic [5:0] exp_vec();
        return {m_stab[0], m_stab[1] & ~m_mf, m_stab[2] & ~m_mf, m_stab[3], m_chg, m_mf};
    endfunction

    function automatic logic [5:0] dut_vec();
        return {Us, Bs, Vs, Adub, Chg, Fault};
    endfunction

    task automatic tick();
        model_step();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_raw(input logic [3:0] v);
        {Adub_raw, Vs_raw, Bs_raw, Us_raw} = v;
    endtask

    task automatic do_reset();
        Rst = 1'b0;
        set_raw(4'b0000);
        tick();
        Rst = 1'b1;
    endtask

    task automatic test_reset();
        Rst = 1'b0;
        set_raw(4'b1111);
        tick();
        tick();
        n_cmp++;
        if (dut_vec() !== 6'b000000) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b want 000000", dut_vec());
        end
        set_raw(4'b0000);
        tick();
        Rst = 1'b1;
    endtask

    task automatic test_latency();
        int k;
        tick();
        Us_raw = 1'b1;
        for (k = 1; k <= 20; k++) begin
            tick();
            if (Us === 1'b1) break;
        end
        n_cmp++;
        if (k != int'(DEB + 2)) begin
            n_bad++;
            $display("FAIL us_latency: got %0d cycles want %0d", k, DEB + 2);
        end
        n_cmp++;
        if (Chg !== 1'b0) begin
            n_bad++;
            $display("FAIL chg_same_cycle: got %b want 0", Chg);
        end
        tick();
        n_cmp++;
        if (Chg !== 1'b1) begin
            n_bad++;
            $display("FAIL chg_pulse: got %b want 1", Chg);
        end
        tick();
        n_cmp++;
        if (Chg !== 1'b0) begin
            n_bad++;
            $display("FAIL chg_one_cycle: got %b want 0", Chg);
        end
    endtask

    task automatic test_glitch();
        int bs_seen = 0;
        int chg_seen = 0;
        Bs_raw = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (Bs === 1'b1) bs_seen++;
            if (Chg === 1'b1) chg_seen++;
        end
        Bs_raw = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (Bs === 1'b1) bs_seen++;
            if (Chg === 1'b1) chg_seen++;
        end
        n_cmp++;
        if (bs_seen != 0 || chg_seen != 0) begin
            n_bad++;
            $display("FAIL glitch: got bs_high=%0d chg=%0d want 0 0", bs_seen, chg_seen);
        end
    endtask

    task automatic test_simultaneous();
        int us_t = -1, ad_t = -1, chg_cnt = 0;
        do_reset();
        Us_raw   = 1'b1;
        Adub_raw = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            tick();
            if (Us === 1'b1 && us_t < 0) us_t = i;
            if (Adub === 1'b1 && ad_t < 0) ad_t = i;
            if (Chg === 1'b1) chg_cnt++;
        end
        n_cmp++;
        if (us_t != int'(DEB + 2) || ad_t != int'(DEB + 2)) begin
            n_bad++;
            $display("FAIL simul_rise: got us=%0d adub=%0d want %0d", us_t, ad_t, DEB + 2);
        end
        n_cmp++;
        if (chg_cnt != 1) begin
            n_bad++;
            $display("FAIL simul_chg: got %0d pulses want 1", chg_cnt);
        end
    endtask

    task automatic test_fault();
        int vs_t = -1, f_t = -1, k;
        do_reset();
        Vs_raw = 1'b1;
        for (k = 1; k <= 40; k++) begin
            tick();
            if (Vs === 1'b1 && vs_t < 0) vs_t = k;
            if (Fault === 1'b1) begin
                f_t = k;
                break;
            end
        end
        n_cmp++;
        if (vs_t != int'(DEB + 2) || f_t != int'(DEB + 2 + FL + 1)) begin
            n_bad++;
            $display("FAIL fault_set: got vs=%0d fault=%0d want %0d %0d", vs_t, f_t, DEB + 2, DEB + FL + 3);
        end
        n_cmp++;
        if (Vs !== 1'b0 || Bs !== 1'b0) begin
            n_bad++;
            $display("FAIL fault_mask: got vs=%b bs=%b want 0 0", Vs, Bs);
        end
        Bs_raw = 1'b1;
        for (k = 1; k <= 40; k++) begin
            tick();
            if (Fault === 1'b0) break;
        end
        n_cmp++;
        if (k != int'(DEB + 2 + FL + 1)) begin
            n_bad++;
            $display("FAIL fault_clear: got %0d cycles want %0d", k, DEB + FL + 3);
        end
        n_cmp++;
        if (Vs !== 1'b1 || Bs !== 1'b1) begin
            n_bad++;
            $display("FAIL fault_unmask: got vs=%b bs=%b want 1 1", Vs, Bs);
        end
    endtask

    task automatic test_transient();
        int f_seen = 0;
        do_reset();
        Vs_raw = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        Bs_raw = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (Fault === 1'b1) f_seen++;
        end
        n_cmp++;
        if (f_seen != 0 || Vs !== 1'b1 || Bs !== 1'b1) begin
            n_bad++;
            $display("FAIL transient: got fault_cycles=%0d vs=%b bs=%b want 0 1 1", f_seen, Vs, Bs);
        end
    endtask

    task automatic test_reset_in_fault();
        do_reset();
        Us_raw = 1'b1;
        Vs_raw = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        n_cmp++;
        if (dut_vec() !== 6'b100001) begin
            n_bad++;
            $display("FAIL pre_reset_fault: got %b want 100001", dut_vec());
        end
        Rst = 1'b0;
        tick();
        n_cmp++;
        if (dut_vec() !== 6'b000000) begin
            n_bad++;
            $display("FAIL mid_fault_reset: got %b want 000000", dut_vec());
        end
        Rst = 1'b1;
        for (int i = 1; i <= int'(DEB + 1); i++) begin
            tick();
            n_cmp++;
            if (dut_vec() !== 6'b000000) begin
                n_bad++;
                $display("FAIL reset_exit_%0d: got %b want 000000", i, dut_vec());
            end
        end
        tick();
        n_cmp++;
        if (dut_vec() !== 6'b101000) begin
            n_bad++;
            $display("FAIL reset_reappear: got %b want 101000", dut_vec());
        end
        tick();
        n_cmp++;
        if (dut_vec() !== 6'b101010) begin
            n_bad++;
            $display("FAIL reset_reappear_chg: got %b want 101010", dut_vec());
        end
    endtask

    task automatic test_random();
        int hold = 0;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (hold == 0) begin
                set_raw(4'($urandom_range(0, 15)));
                hold = $urandom_range(1, 20);
            end
            hold--;
            Rst = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            tick();
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL random_cycle_%0d: got %b want %b (Us Bs Vs Adub Chg Fault)",
                         c, dut_vec(), exp_vec());
            end
        end
        Rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_glitch();
        test_simultaneous();
        test_fault();
        test_transient();
        test_reset_in_fault();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
